// File: rtl/sump_command_receiver_pkg.sv
// Shared SUMP protocol definitions: opcodes, long-command framing constants,
// receiver state encoding and the short-opcode strobe decoder.
// Also used by metadata_sender.
package sump_pkg;

    localparam logic [7:0] OP_RESET    = 8'h00;
    localparam logic [7:0] OP_ARM      = 8'h01;
    localparam logic [7:0] OP_ID       = 8'h02;
    localparam logic [7:0] OP_METADATA = 8'h04;
    localparam logic [7:0] OP_XON      = 8'h11;
    localparam logic [7:0] OP_XOFF     = 8'h13;

    // Number of argument bytes following a long (bit7 set) opcode.
    localparam int unsigned LONG_ARG_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARGS = 2'd1,
        EMIT = 2'd2
    } rx_state_t;

    // Request strobe bits {metadata, id, arm, reset} for a short opcode.
    function automatic logic [3:0] strobe_decode(input logic [7:0] opcode);
        logic [3:0] strb;
        strb = 4'b0000;
        case (opcode)
            OP_RESET:    strb = 4'b0001;
            OP_ARM:      strb = 4'b0010;
            OP_ID:       strb = 4'b0100;
            OP_METADATA: strb = 4'b1000;
            default:     strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sump_command_receiver.sv
// SUMP command receiver: frames the UART byte stream into short (1 byte) and
// long (opcode + 32-bit little-endian argument) commands, presents them on a
// valid/ready port and pulses request strobes for reset/arm/id/metadata.
// Optional macro CMD_TIMEOUT_EN: abandon a long command whose argument bytes
// stop arriving for TIMEOUT_CYCLES clocks and pulse timeout_err.
module sump_command_receiver
    import sump_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_data,
    output logic        cmd_long,
    output logic        sump_reset,
    output logic        arm_req,
    output logic        id_req,
    output logic        metadata_req,
    output logic        timeout_err
);

    rx_state_t   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [31:0] data_q, data_d;
    logic        long_q, long_d;
    logic [3:0]  strobe_q, strobe_d;
    logic        byte_accept;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timeout_err_q, timeout_err_d;
`endif

    // Back-pressure only while a framed command waits for its handshake.
    assign rx_ready    = (state_q != EMIT);
    assign cmd_valid   = (state_q == EMIT);
    assign byte_accept = rx_valid && rx_ready;

    assign cmd_opcode = opcode_q;
    assign cmd_data   = data_q;
    assign cmd_long   = long_q;
    assign {metadata_req, id_req, arm_req, sump_reset} = strobe_q;

    // Next-state: framing, argument assembly and handshake-driven strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opcode_d = opcode_q;
        data_d   = data_q;
        long_d   = long_q;
        strobe_d = 4'b0000;
`ifdef CMD_TIMEOUT_EN
        timer_d       = '0;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (byte_accept) begin
                    opcode_d = rx_data;
                    data_d   = 32'h0;
                    long_d   = 1'b0;
                    cnt_d    = 2'd0;
                    state_d  = rx_data[7] ? ARGS : EMIT;
                end
            end
            ARGS: begin
                if (byte_accept) begin
                    data_d[8*cnt_q +: 8] = rx_data;
                    if (cnt_q == 2'(LONG_ARG_BYTES - 1)) begin
                        long_d  = 1'b1;
                        state_d = EMIT;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
`ifdef CMD_TIMEOUT_EN
                // An argument byte in the timeout cycle still wins.
                else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = IDLE;
                    opcode_d      = 8'h00;
                    data_d        = 32'h0;
                    long_d        = 1'b0;
                    cnt_d         = 2'd0;
                    timeout_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            EMIT: begin
                if (cmd_ready) begin
                    state_d = IDLE;
                    if (!long_q) begin
                        strobe_d = strobe_decode(opcode_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            opcode_q <= 8'h00;
            data_q   <= 32'h0;
            long_q   <= 1'b0;
            strobe_q <= 4'b0000;
`ifdef CMD_TIMEOUT_EN
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opcode_q <= opcode_d;
            data_q   <= data_d;
            long_q   <= long_d;
            strobe_q <= strobe_d;
`ifdef CMD_TIMEOUT_EN
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

`ifdef CMD_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    // Without the timer a long command waits indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: doc/sump_command_receiver.md
Name: sump_command_receiver

Overview:
- Host-side command decoder for the SUMP logic-analyzer protocol.
- Takes the UART receive byte stream and frames it into 1-byte short commands or 5-byte long commands (opcode plus 32-bit argument).
- Presents each framed command on a valid/ready port.
- Raises one-cycle request strobes for reset, arm, ID and metadata; the metadata strobe starts metadata_sender.

Parameters:
- TIMEOUT_CYCLES, 1_000_000: maximum idle clocks between argument bytes of a long command before it is abandoned. Used only with CMD_TIMEOUT_EN.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from UART
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- cmd_valid  out  1  framed command available
- cmd_ready  in  1  consumer accepts command
- cmd_opcode  out  8  command opcode
- cmd_data  out  32  long-command argument; 0 for short commands
- cmd_long  out  1  1 = long command (opcode bit7 set)
- sump_reset  out  1  pulse: opcode 0x00 accepted
- arm_req  out  1  pulse: opcode 0x01 accepted
- id_req  out  1  pulse: opcode 0x02 accepted
- metadata_req  out  1  pulse: opcode 0x04 accepted, drives metadata_sender start
- timeout_err  out  1  pulse: long command abandoned (constant 0 without CMD_TIMEOUT_EN)

Behaviour:
- Reset values: state IDLE; rx_ready=1; cmd_valid=0; cmd_opcode=0; cmd_data=0; cmd_long=0; all strobes=0; arg count=0; timer=0.
- Reset mid-command discards any partial command and drops cmd_valid without handshake.
- States: IDLE, ARGS, EMIT.
  - rx_ready = (state != EMIT), registered-equivalent.
  - No byte is ever lost; back-pressure only.
- IDLE, on accepted byte B:
  - B[7]=0: cmd_opcode=B, cmd_data=0, cmd_long=0, go to EMIT.
  - B[7]=1: cmd_opcode=B, cmd_data=0, cnt=0, go to ARGS.
- ARGS, on accepted byte:
  - Argument is little-endian: cmd_data[8*cnt +: 8] = byte, cnt++.
  - On the 4th byte (cnt==3): cmd_long=1, go to EMIT.
- EMIT:
  - cmd_valid=1; outputs are held stable until cmd_ready.
  - On cmd_valid && cmd_ready: go to IDLE and clear cmd_valid the next cycle.
- Latency:
  - Short command: cmd_valid asserts the cycle after the byte is accepted.
  - Long command: cmd_valid asserts the cycle after the 4th argument byte is accepted.
  - Minimum command-to-command spacing is one cycle (the EMIT→IDLE cycle).
- Strobes:
  - Registered; asserted exactly one cycle, in the cycle after the cmd handshake, and only for short opcodes 0x00/0x01/0x02/0x04.
  - Other short opcodes (e.g. 0x11, 0x13) and all long opcodes are emitted on cmd only.
- Repeated 0x00 bytes: each is a separate short command with its own sump_reset pulse; host resync with five 0x00 bytes gives five pulses.
- cnt is 2 bits and never wraps past 3.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- When defined:
  - Timer of width $clog2(TIMEOUT_CYCLES+1) clears on every accepted byte and increments each cycle in ARGS.
  - When it reaches TIMEOUT_CYCLES: return to IDLE, discard partial data, no cmd_valid, timeout_err=1 for one cycle.
  - A byte accepted in the same cycle as the timeout is taken as an argument byte and the timer clears; the argument byte wins.
- When undefined:
  - No timer logic; ARGS waits indefinitely; timeout_err tied to 0.

Decomposition:
- Package sump_pkg holds:
  - Opcode localparams: OP_RESET=8'h00, OP_ARM=8'h01, OP_ID=8'h02, OP_METADATA=8'h04, OP_XON=8'h11, OP_XOFF=8'h13.
  - LONG_ARG_BYTES=4.
  - State enum typedef rx_state_t {IDLE, ARGS, EMIT}.
- This package is shared with metadata_sender.
- Single module; no sub-module warranted; timeout counter stays inline.

Test Plan:
- Bytes 0x04 with cmd_ready=1 → cmd_valid one cycle later with opcode 0x04, cmd_long=0, data=0; metadata_req pulses once the following cycle.
- Bytes 0xC0,0x78,0x56,0x34,0x12 → one command: opcode 0xC0, cmd_data=32'h12345678, cmd_long=1; no strobes.
- cmd_ready=0 for 10 cycles after a 0x01 → rx_ready low, outputs stable; a byte offered meanwhile is accepted only after the handshake; arm_req pulses once.
- Five 0x00 bytes back-to-back with cmd_ready=1 → five commands, five sump_reset pulses.
- reset asserted after 0x80,0xAA → all outputs return to reset values; then 0x02 → id_req pulses; no stale data appears.
- CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: send 0x81,0x01, then wait 16 cycles → timeout_err pulse, state IDLE; next 0x02 decodes as short.
